// File: rtl/call_stack_unit.sv
// LIFO return-address/data stack driven by the ControlUnit push (StW) and pop (StR) strobes.
// Pops and replaces return the old top through a registered pop_data/pop_valid pair.
module call_stack_unit #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       StW,
   input  logic                       StR,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       err_clr,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       pop_valid,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int IW = $clog2(DEPTH);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [IW-1:0]    top_idx;
   logic [IW-1:0]    wr_idx;
   logic [CW-1:0]    cnt_nxt;
   logic             wr_en;
   logic             rd_en;
   logic             ovf_evt;
   logic             unf_evt;

   assign empty   = (count == '0);
   assign full    = (count == CNT_FULL);
   // Only meaningful when !empty; truncation is safe since count-1 < DEPTH there.
   assign top_idx = IW'(count - CW'(1));

   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = IW'(count);
      rd_en   = 1'b0;
      ovf_evt = 1'b0;
      unf_evt = 1'b0;
      cnt_nxt = count;
      case ({StW, StR})
         2'b10: begin
            if (full) ovf_evt = 1'b1;
            else begin
               wr_en   = 1'b1;
               cnt_nxt = count + CW'(1);
            end
         end
         2'b01: begin
            if (empty) unf_evt = 1'b1;
            else begin
               rd_en   = 1'b1;
               cnt_nxt = count - CW'(1);
            end
         end
         2'b11: begin
            // Replace on an empty stack degrades to a push but still flags the missing pop.
            if (empty) begin
               wr_en   = 1'b1;
               wr_idx  = '0;
               cnt_nxt = CW'(1);
               unf_evt = 1'b1;
            end else begin
               rd_en  = 1'b1;
               wr_en  = 1'b1;
               wr_idx = top_idx;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= '0;
         pop_data  <= '0;
         pop_valid <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         count     <= cnt_nxt;
         pop_valid <= rd_en;
         if (rd_en) pop_data <= mem[top_idx];
         overflow  <= ovf_evt | (overflow  & ~err_clr);
         underflow <= unf_evt | (underflow & ~err_clr);
      end
   end

endmodule

// File: tb/tb_call_stack_unit.sv
// Directed bench for call_stack_unit: reset, LIFO order, full/empty limits, errors, replace.
module tb_call_stack_unit;

   localparam int WIDTH = 32;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH+1);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             StW, StR, err_clr;
   logic [WIDTH-1:0] push_data;
   logic [WIDTH-1:0] pop_data;
   logic             pop_valid, empty, full, overflow, underflow;
   logic [CW-1:0]    count;

   int n_cmp = 0;
   int n_err = 0;

   call_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .StW(StW), .StR(StR), .push_data(push_data),
      .err_clr(err_clr), .pop_data(pop_data), .pop_valid(pop_valid), .count(count),
      .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of strobes; return 1 time unit after the edge with strobes idle.
   task automatic step(input logic w, input logic r, input logic [31:0] d, input logic ec);
      StW = w; StR = r; push_data = d; err_clr = ec;
      @(posedge clk);
      #1;
      StW = 1'b0; StR = 1'b0; err_clr = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; StW = 1'b0; StR = 1'b0; err_clr = 1'b0; push_data = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: build some state, then reset asynchronously mid-push
      step(1, 0, 32'h11, 0);
      step(0, 1, 32'h0, 0);
      chk("pre_rst_pop", pop_data, 32'h11);
      step(0, 1, 32'h0, 0);
      chk("pre_rst_unf", 32'(underflow), 32'd1);
      step(1, 0, 32'h22, 0);
      StW = 1'b1; push_data = 32'h77;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_pop_data", pop_data, 32'h0);
      chk("rst_unf", 32'(underflow), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_pop_valid", 32'(pop_valid), 32'd0);
      StW = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // 2: LIFO order with back-to-back pop pulses
      step(1, 0, 32'h100, 0);
      step(1, 0, 32'h200, 0);
      step(1, 0, 32'h300, 0);
      chk("lifo_count3", 32'(count), 32'd3);
      step(0, 1, 32'h0, 0);
      chk("lifo_pop1", pop_data, 32'h300);
      chk("lifo_vld1", 32'(pop_valid), 32'd1);
      step(0, 1, 32'h0, 0);
      chk("lifo_pop2", pop_data, 32'h200);
      chk("lifo_vld2", 32'(pop_valid), 32'd1);
      step(0, 1, 32'h0, 0);
      chk("lifo_pop3", pop_data, 32'h100);
      chk("lifo_vld3", 32'(pop_valid), 32'd1);
      chk("lifo_empty", 32'(empty), 32'd1);
      step(0, 0, 32'h0, 0);
      chk("lifo_vld_idle", 32'(pop_valid), 32'd0);

      // 3: fill, overflow, pop returns the 8th value
      for (int i = 0; i < DEPTH; i++) step(1, 0, 32'h1000 + i, 0);
      chk("full_flag", 32'(full), 32'd1);
      chk("full_count", 32'(count), 32'd8);
      chk("full_ovf0", 32'(overflow), 32'd0);
      step(1, 0, 32'hDEAD, 0);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(count), 32'd8);
      step(0, 1, 32'h0, 0);
      chk("ovf_pop", pop_data, 32'h1007);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      step(0, 0, 32'h0, 1);
      chk("ovf_clr", 32'(overflow), 32'd0);
      for (int i = 0; i < DEPTH-1; i++) step(0, 1, 32'h0, 0);
      chk("drain_last", pop_data, 32'h1000);
      chk("drain_empty", 32'(empty), 32'd1);

      // 4: pop on empty, clear, clear colliding with new error
      step(0, 1, 32'h0, 0);
      chk("unf_set", 32'(underflow), 32'd1);
      chk("unf_vld", 32'(pop_valid), 32'd0);
      chk("unf_data_held", pop_data, 32'h1000);
      step(0, 0, 32'h0, 1);
      chk("unf_clr", 32'(underflow), 32'd0);
      step(0, 1, 32'h0, 1);
      chk("unf_clr_collide", 32'(underflow), 32'd1);
      step(0, 0, 32'h0, 1);

      // 5: replace
      step(1, 0, 32'hA, 0);
      step(1, 0, 32'hB, 0);
      step(1, 1, 32'hC, 0);
      chk("rep_data", pop_data, 32'hB);
      chk("rep_vld", 32'(pop_valid), 32'd1);
      chk("rep_count", 32'(count), 32'd2);
      step(0, 1, 32'h0, 0);
      chk("rep_pop_new", pop_data, 32'hC);
      step(0, 1, 32'h0, 0);
      chk("rep_pop_bot", pop_data, 32'hA);

      // 6: replace when full and when empty
      for (int i = 0; i < DEPTH; i++) step(1, 0, 32'h2000 + i, 0);
      step(1, 1, 32'h99, 0);
      chk("repf_ovf", 32'(overflow), 32'd0);
      chk("repf_count", 32'(count), 32'd8);
      chk("repf_data", pop_data, 32'h2007);
      step(0, 1, 32'h0, 0);
      chk("repf_pop", pop_data, 32'h99);
      for (int i = 0; i < DEPTH-1; i++) step(0, 1, 32'h0, 0);
      chk("repf_drained", 32'(empty), 32'd1);
      chk("repf_unf0", 32'(underflow), 32'd0);
      step(1, 1, 32'h55, 0);
      chk("repe_count", 32'(count), 32'd1);
      chk("repe_unf", 32'(underflow), 32'd1);
      chk("repe_vld", 32'(pop_valid), 32'd0);
      step(0, 1, 32'h0, 0);
      chk("repe_pop", pop_data, 32'h55);
      chk("repe_pop_vld", 32'(pop_valid), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
